alu_iter_exec: RTL and testbench
================================

// Module: alu_iter_exec
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit ALUop code (`ALU_* from ALUop.vh) produced by the ALU decoder.
//  Logic/arith/compare ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle.
//  Operands enter and results leave through valid/ready handshakes.
//  Sits between operand mux and writeback/forwarding logic.
// PARAMETERS
//  WIDTH       32  datapath width; fixed at 32 (shamt field = op_b[4:0])
//  SHIFT_STEP  8   max shift distance per cycle; power of 2, 1..32
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      alu_op/op_a/op_b valid
//  in_ready   out  1      block can accept an op
//  alu_op     in   4      `ALU_* operation code
//  op_a       in   WIDTH  operand A (shift source)
//  op_b       in   WIDTH  operand B (shift amount in [4:0])
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  operation result
//  bad_op     out  1      result is for an unsupported/`ALU_XXX code
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, bad_op=0, busy=0; in_ready=0 while rst=1.
//  Reset mid-op aborts; the result is never presented.
//  States:
//   - IDLE: in_ready=1. Accept on in_valid&&in_ready; operands and op are sampled only then.
//   - SHIFT: working reg shifts by min(SHIFT_STEP, rem) each cycle; rem decrements by the same amount.
//   - DONE: out_valid=1; result/bad_op held stable until out_valid&&out_ready.
//  Transitions:
//   - IDLE->DONE on accept of a non-shift op, or a shift with shamt==0.
//   - IDLE->SHIFT on accept of a shift with shamt!=0.
//   - SHIFT->DONE in the cycle rem reaches 0.
//   - DONE->IDLE on handshake. No same-cycle re-accept: in_ready=0 in SHIFT and DONE.
//  Latency (accept edge to out_valid high): 1 cycle for non-shift ops; 1+ceil(shamt/SHIFT_STEP) for shifts.
//  Ops (all mod 2^WIDTH, no overflow flag):
//   - ADD a+b; SUB a-b; AND/OR/XOR bitwise.
//   - SLT signed a<b, SLTU unsigned a<b; both give 1/0 zero-extended.
//   - SLL, SRL zero-fill; SRA fills with op_a[WIDTH-1] sampled at accept.
//   - COPY_B = b.
//  Any other code (incl. `ALU_XXX): result=0, bad_op=1, 1-cycle latency, normal handshake.
//  op_b[WIDTH-1:5] is ignored for shifts.
//  busy=1 in SHIFT and DONE.
//  out_ready high in a non-DONE state has no effect.
// TESTING
//  ADD 0x7FFFFFFF,0x00000001 -> result 0x80000000, out_valid 1 cycle after accept, bad_op=0
//  SUB 0,1 -> 0xFFFFFFFF. SLT 0xFFFFFFFF,0 -> 1. SLTU 0xFFFFFFFF,0 -> 0. COPY_B x,0x1234 -> 0x1234
//  SRA 0x80000000, op_b=0xFFFFFFFF (shamt 31), STEP=8 -> 0xFFFFFFFF, out_valid 5 cycles after accept
//  SLL 0x1,shamt 0 -> 0x1 after 1 cycle; SRL 0x80000000, shamt 9, STEP=8 -> 0x00400000 after 3 cycles
//  ADD 2,3 with out_ready=0 for 3 cycles -> result 5 and out_valid held, in_ready=0; IDLE after handshake
//  rst=1 mid-SHIFT -> next cycle out_valid=0, busy=0, no result emitted
//  alu_op=`ALU_XXX -> result 0, bad_op=1, 1-cycle latency

Source files
------------

// File: rtl/alu_iter_exec_if.sv
// Operand-in / result-out handshake bundle for the iterative execute-stage ALU.
// master drives operands and consumes results; slave is the ALU side.
interface alu_iter_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bad_op;
  logic             busy;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, bad_op, busy
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, bad_op, busy
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, shifts iterated
// SHIFT_STEP bits per cycle, valid/ready on both operand and result sides.
module alu_iter_exec #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_iter_exec_if.slave bus
);

  // Opcode encoding shared with the ALU decoder (ALUop.vh).
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [4:0]       rem_reg;
  logic             left_reg;
  logic             fill_reg;
  logic             bad_op_reg;

  logic [WIDTH-1:0] calc_res;
  logic             calc_bad;
  logic             calc_shift;
  logic [4:0]       shamt;
  logic [5:0]       step;
  logic [4:0]       rem_next;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shift_next;

  assign shamt = bus.op_b[4:0];

  always_comb begin
    calc_res   = '0;
    calc_bad   = 1'b0;
    calc_shift = 1'b0;
    case (bus.alu_op)
      ALU_ADD:    calc_res = bus.op_a + bus.op_b;
      ALU_SUB:    calc_res = bus.op_a - bus.op_b;
      ALU_AND:    calc_res = bus.op_a & bus.op_b;
      ALU_OR:     calc_res = bus.op_a | bus.op_b;
      ALU_XOR:    calc_res = bus.op_a ^ bus.op_b;
      ALU_SLT:    calc_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      ALU_SLTU:   calc_res = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
      ALU_COPY_B: calc_res = bus.op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: calc_shift = 1'b1;
      default:    calc_bad = 1'b1;
    endcase
  end

  // Never overshoot the remaining distance, so step <= rem_reg <= 31.
  assign step     = ({1'b0, rem_reg} > STEP_MAX) ? STEP_MAX : {1'b0, rem_reg};
  assign rem_next = rem_reg - step[4:0];

  // Top 'step' bits set: the vacated positions an arithmetic right shift refills.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fill
      assign fill_mask[gi] = (7'(gi) + {1'b0, step}) >= 7'(WIDTH);
    end
  endgenerate

  assign shift_next = left_reg ? (work_reg << step)
                               : ((work_reg >> step) | (fill_reg ? fill_mask : '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      rem_reg    <= '0;
      left_reg   <= 1'b0;
      fill_reg   <= 1'b0;
      bad_op_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            bad_op_reg <= calc_bad;
            left_reg   <= (bus.alu_op == ALU_SLL);
            fill_reg   <= (bus.alu_op == ALU_SRA) && bus.op_a[WIDTH-1];
            rem_reg    <= shamt;
            if (calc_shift) begin
              work_reg  <= bus.op_a;
              state_reg <= (shamt == 5'd0) ? DONE : SHIFT;
            end else begin
              work_reg  <= calc_res;
              state_reg <= DONE;
            end
          end
        end
        SHIFT: begin
          work_reg <= shift_next;
          rem_reg  <= rem_next;
          if (rem_next == 5'd0) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.result    = work_reg;
  assign bus.bad_op    = bad_op_reg;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed-vector bench for alu_iter_exec (SHIFT_STEP = 8): result, bad_op,
// latency, result hold under backpressure and mid-shift reset abort.
module tb_alu_iter_exec;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SLTU   = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_COPY_B = 4'd10;
  localparam logic [3:0] OP_XXX    = 4'd15;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_iter_exec_if #(.WIDTH(32)) bus ();

  alu_iter_exec #(.WIDTH(32), .SHIFT_STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency, hold the result for 'hold' cycles, then handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_bad, input int exp_lat, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'h0000_0003;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".bad_op"}, 32'(bus.bad_op), 32'(exp_bad));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_result"}, bus.result, exp_res);
      check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, ".hold_busy"}, 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_busy"}, 32'(bus.busy), 32'd0);
    $display("vec %-6s op=%0d a=0x%08h b=0x%08h -> 0x%08h bad=%0b lat=%0d",
             tag, op, a, b, bus.result, bus.bad_op, lat);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = OP_ADD;
    bus.op_a      = '0;
    bus.op_b      = '0;
    tick();
    tick();
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.bad_op", 32'(bus.bad_op), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    check("idle.in_ready", 32'(bus.in_ready), 32'd1);

    // out_ready while idle must be ignored
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle.out_valid", 32'(bus.out_valid), 32'd0);

    run_op("add",   OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1, 0);
    run_op("sub",   OP_SUB,    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("and",   OP_AND,    32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 0);
    run_op("or",    OP_OR,     32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF, 1'b0, 1, 0);
    run_op("xor",   OP_XOR,    32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1, 0);
    run_op("slt",   OP_SLT,    32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1, 0);
    run_op("sltu",  OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0);
    run_op("sltu2", OP_SLTU,   32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 1, 0);
    run_op("copyb", OP_COPY_B, 32'h5A5A_5A5A, 32'h0000_1234, 32'h0000_1234, 1'b0, 1, 0);
    run_op("sra31", OP_SRA,    32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 0);
    run_op("sll0",  OP_SLL,    32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1, 0);
    run_op("srl9",  OP_SRL,    32'h8000_0000, 32'h0000_0009, 32'h0040_0000, 1'b0, 3, 0);
    run_op("sll31", OP_SLL,    32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 5, 0);
    run_op("srapos",OP_SRA,    32'h4000_0000, 32'h0000_0008, 32'h0040_0000, 1'b0, 2, 0);
    run_op("sra12", OP_SRA,    32'hF000_0000, 32'h0000_000C, 32'hFFFF_0000, 1'b0, 3, 0);
    run_op("srlhi", OP_SRL,    32'h0000_00F0, 32'hFFFF_FFE4, 32'h0000_000F, 1'b0, 2, 0);
    run_op("hold",  OP_ADD,    32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1, 3);
    run_op("xxx",   OP_XXX,    32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b1, 1, 0);
    run_op("after", OP_ADD,    32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1, 0);

    // Reset during a long shift: nothing may be presented afterwards.
    bus.alu_op   = OP_SRA;
    bus.op_a     = 32'h8000_0000;
    bus.op_b     = 32'h0000_001F;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.in_ready_rst", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort.no_result", 32'(bus.out_valid), 32'd0);
    end
    check("abort.in_ready", 32'(bus.in_ready), 32'd1);
    $display("vec abort  SRA reset mid-shift out_valid=%0b busy=%0b", bus.out_valid, bus.busy);

    run_op("recov", OP_SUB, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
